bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble (shift-and-add-3) converter from unsigned binary to packed BCD digits.
- Sits directly upstream of the 7-segment digit decoders in the switch-to-HEX display path and replaces the combinational divide/modulo digit split.
- Start/busy/done handshake. Optional leading-zero blanking emits the decoder's blank code.

---
 rtl/bin_to_bcd_seq_pkg.sv | 20 ++
 rtl/bcd_add3_digit.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 97 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam logic [3:0] BCD_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // 10**n, evaluated at elaboration for the overflow threshold
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter with
// optional leading-zero blanking for the 7-segment decoders.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;
  // Representation of 0: units digit 0, upper digits blank when enabled
  localparam logic [4*DIGITS-1:0] BCD_RST =
    (BLANK_LEADING != 0) ? ({(4*DIGITS){1'b1}} << 4) : '0;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    bsr;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] bcd_nxt;
  logic                ovf_q;
  logic                lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (
      .d(acc[4*g +: 4]),
      .q(acc_adj[4*g +: 4])
    );
  end

  // Blank zero digits above the first nonzero one; overflow blanks all
  always_comb begin
    bcd_nxt = acc;
    lead    = 1'b1;
    if (BLANK_LEADING != 0) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && (acc[4*k +: 4] == 4'd0)) bcd_nxt[4*k +: 4] = BCD_BLANK;
        else                                 lead = 1'b0;
      end
    end
    if (ovf_q) bcd_nxt = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      ovf_q <= 1'b0;
      cnt   <= '0;
      bsr   <= '0;
      acc   <= '0;
      bcd   <= BCD_RST;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bsr   <= bin;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            ovf_q <= (64'(bin) > MAXV);
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= {acc_adj[4*DIGITS-2:0], bsr[WIDTH-1]};
          bsr <= bsr << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd   <= bcd_nxt;
          ovf   <= ovf_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations driven in lockstep and
// compared against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;

  logic        busy0, done0, ovf0;
  logic [15:0] bcd0;
  logic        busy1, done1, ovf1;
  logic [15:0] bcd1;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(1)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0));

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(0)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1));

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2));

  // Display value of v on a digits-wide decoder row
  function automatic logic [63:0] model_bcd(input int v, input int digits, input bit blank);
    logic [63:0] r;
    int p, d;
    bit lead;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    if (v >= p) return (64'd1 << (4 * digits)) - 64'd1;
    r = '0;
    lead = 1'b1;
    for (int i = digits - 1; i >= 0; i--) begin
      p = p / 10;
      d = (v / p) % 10;
      if (blank && lead && d == 0 && i > 0) r = (r << 4) | 64'hF;
      else begin
        lead = 1'b0;
        r = (r << 4) | 64'(d);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] model_ovf(input int v, input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return (v >= p) ? 64'd1 : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int v);
    chk({tag, "_bcd0"}, 64'(bcd0), model_bcd(v, 4, 1'b1));
    chk({tag, "_ovf0"}, 64'(ovf0), model_ovf(v, 4));
    chk({tag, "_bcd1"}, 64'(bcd1), model_bcd(v, 4, 1'b0));
    chk({tag, "_ovf1"}, 64'(ovf1), model_ovf(v, 4));
    chk({tag, "_bcd2"}, 64'(bcd2), model_bcd(v, 3, 1'b1));
    chk({tag, "_ovf2"}, 64'(ovf2), model_ovf(v, 3));
  endtask

  // One conversion; cycle c is the cycle after the c-th edge following the start edge
  task automatic run_conv(input int v, input bit intrude);
    bit early_done;
    early_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bin   = 10'(v);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 1) chk("busy_rise", 64'(busy0), 64'd1);
      if (c < 12 && (done0 || done1 || done2)) early_done = 1'b1;
      if (c == 11) begin
        chk("early_done", 64'(early_done), 64'd0);
        chk("busy_c11", 64'(busy0), 64'd1);
      end
      if (c == 12) begin
        chk("done0", 64'(done0), 64'd1);
        chk("done1", 64'(done1), 64'd1);
        chk("done2", 64'(done2), 64'd1);
        chk("busy_fall", 64'(busy0), 64'd0);
        chk_outputs("conv", v);
      end
      if (c == 13) chk("done_pulse_len", 64'(done0), 64'd0);
      if (intrude && c == 4) begin
        start = 1'b1;
        bin   = 10'd3;
      end
      if (intrude && c == 5) start = 1'b0;
      if (c < 13) @(negedge clk);
    end
  endtask

  initial begin
    int dir[7] = '{1023, 0, 7, 999, 100, 1000, 999};
    int v;
    bit seen;

    // Reset state
    rst = 1'b1;
    #12;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk_outputs("rst", 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values, including the 3-digit overflow boundary
    foreach (dir[i]) run_conv(dir[i], 1'b0);

    // Start while busy is ignored; result holds afterwards
    run_conv(512, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_busy", 64'(busy0), 64'd0);
    chk_outputs("hold", 512);

    // Reset asserted mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk_outputs("abort", 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done0 || done1 || done2 || busy0) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk_outputs("abort_hold", 0);
    run_conv(1000, 1'b0);

    // Randomized values
    for (int n = 0; n < 20; n++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
